// File: rtl/fp_norm_pipe.sv
// Two-stage normaliser between the significand adder and the rounder.
// Stage 1 registers the raw beat with its leading-zero count; stage 2 shifts, adjusts the exponent and flags.
`timescale 1ns/1ps
module fp_norm_pipe #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W+1:0] in_sig,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    input  logic              in_sticky,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_sig,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic              out_guard,
    output logic              out_sticky,
    output logic              out_zero,
    output logic              out_underflow,
    output logic              out_overflow
);
    localparam int SIG_W = MANT_W + 2;
    localparam int LZW   = $clog2(SIG_W);

    // Leading zeros of the hidden+fraction field; all-zero yields the field width.
    function automatic logic [LZW-1:0] lzc(input logic [SIG_W-2:0] v);
        logic found;
        lzc   = LZW'(SIG_W - 1);
        found = 1'b0;
        for (int i = SIG_W - 2; i >= 0; i--) begin
            if (!found && v[i]) begin
                lzc   = LZW'(SIG_W - 2 - i);
                found = 1'b1;
            end
        end
    endfunction

    logic              r_s1_valid;
    logic [SIG_W-2:0]  r_s1_sig;
    logic [EXP_W-1:0]  r_s1_exp;
    logic              r_s1_sign;
    logic              r_s1_sticky;
    logic [LZW-1:0]    r_s1_lz;
    logic              r_s1_carry;
    logic              r_s1_nz;

    logic              r_s2_valid;
    logic [MANT_W-1:0] r_out_sig;
    logic [EXP_W-1:0]  r_out_exp;
    logic              r_out_sign;
    logic              r_out_guard;
    logic              r_out_sticky;
    logic              r_out_zero;
    logic              r_out_underflow;
    logic              r_out_overflow;

    logic              w_s1_load;
    logic              w_s2_load;
    logic [EXP_W:0]    w_exp_ext;
    logic [EXP_W:0]    w_lz_ext;
    logic [EXP_W:0]    w_exp_inc;
    logic [EXP_W:0]    w_exp_dec;
    logic [SIG_W-2:0]  w_shl;

    logic [MANT_W-1:0] w_n_sig;
    logic [EXP_W-1:0]  w_n_exp;
    logic              w_n_guard;
    logic              w_n_sticky;
    logic              w_n_zero;
    logic              w_n_underflow;
    logic              w_n_overflow;

    // A stage accepts when it is empty or the stage after it is moving.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    // Stage 1: capture beat and leading-zero count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_sig    <= {(SIG_W-1){1'b0}};
            r_s1_exp    <= {EXP_W{1'b0}};
            r_s1_sign   <= 1'b0;
            r_s1_sticky <= 1'b0;
            r_s1_lz     <= {LZW{1'b0}};
            r_s1_carry  <= 1'b0;
            r_s1_nz     <= 1'b0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_load) begin
                r_s1_valid <= in_valid;
            end
            if (w_s1_load && in_valid) begin
                r_s1_sig    <= in_sig[SIG_W-2:0];
                r_s1_exp    <= in_exp;
                r_s1_sign   <= in_sign;
                r_s1_sticky <= in_sticky;
                r_s1_lz     <= lzc(in_sig[SIG_W-2:0]);
                r_s1_carry  <= in_sig[SIG_W-1];
                r_s1_nz     <= |in_sig;
            end
        end
    end

    // Exponent math one bit wider than the field so nothing wraps silently.
    assign w_exp_ext = {1'b0, r_s1_exp};
    assign w_lz_ext  = {{(EXP_W+1-LZW){1'b0}}, r_s1_lz};
    assign w_exp_inc = w_exp_ext + {{EXP_W{1'b0}}, 1'b1};
    assign w_exp_dec = w_exp_ext - w_lz_ext;
    assign w_shl     = r_s1_sig << r_s1_lz;

    // Stage 2 result selection: zero, carry/overflow, then left shift/underflow.
    always_comb begin
        w_n_sig       = {MANT_W{1'b0}};
        w_n_exp       = {EXP_W{1'b0}};
        w_n_guard     = 1'b0;
        w_n_sticky    = r_s1_sticky;
        w_n_zero      = 1'b0;
        w_n_underflow = 1'b0;
        w_n_overflow  = 1'b0;
        if (!r_s1_nz) begin
            w_n_zero = 1'b1;
        end else if (r_s1_carry) begin
            w_n_guard = r_s1_sig[0];
            if (w_exp_inc >= {1'b0, {EXP_W{1'b1}}}) begin
                w_n_exp      = {EXP_W{1'b1}};
                w_n_overflow = 1'b1;
            end else begin
                w_n_exp = w_exp_inc[EXP_W-1:0];
                w_n_sig = r_s1_sig[SIG_W-2:1];
            end
        end else if (w_exp_ext <= w_lz_ext) begin
            w_n_zero      = 1'b1;
            w_n_underflow = 1'b1;
            w_n_sticky    = 1'b0;
        end else begin
            w_n_exp = w_exp_dec[EXP_W-1:0];
            w_n_sig = w_shl[MANT_W-1:0];
        end
    end

    // Stage 2: output registers, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid      <= 1'b0;
            r_out_sig       <= {MANT_W{1'b0}};
            r_out_exp       <= {EXP_W{1'b0}};
            r_out_sign      <= 1'b0;
            r_out_guard     <= 1'b0;
            r_out_sticky    <= 1'b0;
            r_out_zero      <= 1'b0;
            r_out_underflow <= 1'b0;
            r_out_overflow  <= 1'b0;
        end else begin
            if (flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_load && r_s1_valid) begin
                r_out_sig       <= w_n_sig;
                r_out_exp       <= w_n_exp;
                r_out_sign      <= r_s1_sign;
                r_out_guard     <= w_n_guard;
                r_out_sticky    <= w_n_sticky;
                r_out_zero      <= w_n_zero;
                r_out_underflow <= w_n_underflow;
                r_out_overflow  <= w_n_overflow;
            end
        end
    end

    assign out_valid     = r_s2_valid;
    assign out_sig       = r_out_sig;
    assign out_exp       = r_out_exp;
    assign out_sign      = r_out_sign;
    assign out_guard     = r_out_guard;
    assign out_sticky    = r_out_sticky;
    assign out_zero      = r_out_zero;
    assign out_underflow = r_out_underflow;
    assign out_overflow  = r_out_overflow;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Self-checking bench for fp_norm_pipe (MANT_W=23, EXP_W=8): directed literal cases,
// backpressure, flush, reset, then a randomized stream against an arithmetic reference model.
`timescale 1ns/1ps
module tb_fp_norm_pipe;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_sign, in_sticky;
    logic [24:0] in_sig;
    logic [7:0]  in_exp;
    logic        out_valid, out_ready, out_sign, out_guard, out_sticky;
    logic        out_zero, out_underflow, out_overflow;
    logic [22:0] out_sig;
    logic [7:0]  out_exp;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    typedef struct packed {
        logic [22:0] sig;
        logic [7:0]  e;
        logic        sign, guard, sticky, zero, uf, of;
    } res_t;

    res_t q[$];

    always #5 clk = ~clk;

    fp_norm_pipe #(.MANT_W(23), .EXP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sig(in_sig), .in_exp(in_exp), .in_sign(in_sign), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sig(out_sig), .out_exp(out_exp), .out_sign(out_sign),
        .out_guard(out_guard), .out_sticky(out_sticky),
        .out_zero(out_zero), .out_underflow(out_underflow), .out_overflow(out_overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: value-level normalisation with plain integers.
    function automatic res_t model(input logic [24:0] s, input logic [7:0] e,
                                   input logic sg, input logic st);
        res_t   r;
        int     p, lz, ex;
        longint m;
        r = '0;
        r.sign   = sg;
        r.sticky = st;
        if (s == 25'd0) begin
            r.zero = 1'b1;
        end else if (s[24]) begin
            ex      = int'(e) + 1;
            r.guard = s[0];
            if (ex >= 255) begin
                r.e  = 8'hff;
                r.of = 1'b1;
            end else begin
                r.e   = 8'(ex);
                r.sig = s[23:1];
            end
        end else begin
            p = 0;
            for (int i = 23; i >= 0; i--) begin
                if (s[i]) begin
                    p = i;
                    break;
                end
            end
            lz = 23 - p;
            if (int'(e) <= lz) begin
                r.zero   = 1'b1;
                r.uf     = 1'b1;
                r.sticky = 1'b0;
            end else begin
                m     = longint'(s) * (longint'(1) << lz);
                r.sig = 23'(m % (longint'(1) << 23));
                r.e   = 8'(int'(e) - lz);
            end
        end
        return r;
    endfunction

    function automatic res_t dut_res();
        return {out_sig, out_exp, out_sign, out_guard, out_sticky, out_zero, out_underflow, out_overflow};
    endfunction

    // Scoreboard: compare every valid output cycle against the oldest pending result.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
                else               chk("stream", 64'(dut_res()), 64'(q[0]));
            end
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() > 0) begin
                    void'(q.pop_front());
                    n_out++;
                end
                if (in_valid && in_ready) q.push_back(model(in_sig, in_exp, in_sign, in_sticky));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // One beat into an empty pipe; checks latency and literal expectations.
    task automatic directed(input string nm, input logic [24:0] s, input logic [7:0] e,
                            input logic st, input logic [22:0] xs, input logic [7:0] xe,
                            input logic [2:0] xflags, input logic [1:0] xgs, input bit do_gs);
        in_sig = s; in_exp = e; in_sticky = st; in_sign = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_lat1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({nm, "_lat2"}, 64'(out_valid), 64'd1);
        chk({nm, "_sig"}, 64'(out_sig), 64'(xs));
        chk({nm, "_exp"}, 64'(out_exp), 64'(xe));
        chk({nm, "_flags"}, 64'({out_zero, out_underflow, out_overflow}), 64'(xflags));
        if (do_gs) chk({nm, "_gs"}, 64'({out_guard, out_sticky}), 64'(xgs));
        @(posedge clk); #1;
    endtask

    function automatic logic [24:0] rand_sig();
        logic [24:0] r, mask;
        int k;
        case ($urandom_range(0, 4))
            0: r = 25'd0;
            1: r = {1'b1, 24'($urandom)};
            2: r = {2'b01, 23'($urandom)};
            3: begin
                k    = $urandom_range(0, 23);
                mask = (25'd1 << k) - 25'd1;
                r    = 25'($urandom) & mask;
                if (r == 25'd0) r = 25'd1;
            end
            default: r = 25'($urandom);
        endcase
        return r;
    endfunction

    function automatic logic [7:0] rand_exp();
        logic [7:0] r;
        if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 8))
                0: r = 8'd0;   1: r = 8'd1;   2: r = 8'd2;
                3: r = 8'd22;  4: r = 8'd23;  5: r = 8'd24;
                6: r = 8'd253; 7: r = 8'd254; default: r = 8'd255;
            endcase
        end else begin
            r = 8'($urandom);
        end
        return r;
    endfunction

    initial begin
        int  acc, cyc, stall_low, out0;
        logic a, hold;
        logic [24:0] bsig [8];

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sig = 25'd0; in_exp = 8'd0;
        in_sign = 1'b0; in_sticky = 1'b0; out_ready = 1'b1;
        #12;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_outs", 64'(dut_res()), 64'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        directed("carry",  25'h1000001, 8'd100, 1'b0, 23'h000000, 8'd101, 3'b000, 2'b10, 1'b1);
        directed("norm",   25'h0800001, 8'd100, 1'b1, 23'h000001, 8'd100, 3'b000, 2'b01, 1'b1);
        directed("deep",   25'h0000003, 8'd100, 1'b0, 23'h400000, 8'd78,  3'b000, 2'b00, 1'b1);
        directed("zero",   25'h0000000, 8'd77,  1'b0, 23'h000000, 8'd0,   3'b100, 2'b00, 1'b1);
        directed("uflow",  25'h0000001, 8'd23,  1'b1, 23'h000000, 8'd0,   3'b110, 2'b00, 1'b1);
        directed("exp24",  25'h0000001, 8'd24,  1'b0, 23'h000000, 8'd1,   3'b000, 2'b00, 1'b1);
        directed("ovf",    25'h1000001, 8'd254, 1'b0, 23'h000000, 8'd255, 3'b001, 2'b00, 1'b0);
        directed("ovf255", 25'h1400000, 8'd255, 1'b0, 23'h000000, 8'd255, 3'b001, 2'b00, 1'b0);

        // Backpressure: 8 beats, downstream stalled for cycles 3..5.
        for (int i = 0; i < 8; i++) bsig[i] = {2'b01, 23'($urandom)};
        acc = 0; cyc = 0; stall_low = 0; out0 = n_out;
        while (acc < 8 && cyc < 40) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = 1'b1;
            in_sig    = bsig[acc];
            in_exp    = 8'(100 + acc);
            @(negedge clk);
            a = in_ready;
            if (!a) stall_low++;
            @(posedge clk); #1;
            if (a) acc++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_accept_cycles", 64'(cyc), 64'd11);
        chk("bp_ready_low", 64'(stall_low), 64'd3);
        chk("bp_delivered", 64'(n_out - out0), 64'd8);

        // Flush with two beats in flight: nothing is delivered.
        out0 = n_out;
        in_valid = 1'b1; in_sig = 25'h0900000; in_exp = 8'd50;
        @(posedge clk); #1;
        in_sig = 25'h0A00000;
        @(posedge clk); #1;
        in_sig = 25'h0B00000; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("flush_valid_later", 64'(out_valid), 64'd0);
        chk("flush_delivered", 64'(n_out - out0), 64'd0);

        // Reset while both stages are full and stalled.
        out0 = n_out; out_ready = 1'b0;
        in_valid = 1'b1; in_sig = 25'h1FFFFFF; in_exp = 8'd200; in_sticky = 1'b1; in_sign = 1'b1;
        @(posedge clk); #1;
        in_sig = 25'h0C00000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        chk("pre_reset_ready", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 64'(out_valid), 64'd0);
        chk("async_reset_outs", 64'(dut_res()), 64'd0);
        @(posedge clk); #3 rst_n = 1'b1; out_ready = 1'b1; in_sticky = 1'b0; in_sign = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_ready", 64'(in_ready), 64'd1);
        chk("reset_delivered", 64'(n_out - out0), 64'd0);
        directed("after_rst", 25'h0800001, 8'd100, 1'b0, 23'h000001, 8'd100, 3'b000, 2'b00, 1'b1);

        // Randomized traffic with random stalls and occasional flush.
        hold = 1'b0;
        repeat (500) begin
            if (!hold) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_sig    = rand_sig();
                in_exp    = rand_exp();
                in_sign   = 1'($urandom);
                in_sticky = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            hold = in_valid && !in_ready && !flush;
            @(posedge clk); #1;
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
